// File: rtl/product_bcd_converter_if.sv
// Handshake bundle between the product source and the BCD converter.
//   start  : request a conversion of binary (master -> slave)
//   binary : unsigned value to convert      (master -> slave)
//   ready  : converter idle, start accepted (slave -> master)
//   valid  : one-cycle result strobe        (slave -> master)
//   bcd    : packed BCD digits, MSD on top  (slave -> master)
//   blank  : per-digit leading-zero mask    (slave -> master)
interface product_bcd_converter_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) ();

   logic                  start;
   logic [WIDTH-1:0]      binary;
   logic                  ready;
   logic                  valid;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     blank;

   modport master (
      output start, binary,
      input  ready, valid, bcd, blank
   );

   modport slave (
      input  start, binary,
      output ready, valid, bcd, blank
   );

endinterface

// File: rtl/product_bcd_converter.sv
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
// Accepts a WIDTH-bit value on start/ready, returns DIGITS packed BCD digits
// and a leading-zero blank mask WIDTH cycles later with a one-cycle valid.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of product_bcd_converter_if (start, binary, ready,
//           valid, bcd, blank)
module product_bcd_converter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DIGITS     = 3,
   parameter int unsigned COUNT_BITS = 4
) (
   input logic                    clock,
   input logic                    reset,
   product_bcd_converter_if.slave bus
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   // Reset display shows a single "0": every digit blanked except digit 0.
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e                  state_q,   state_d;
   logic [WIDTH-1:0]        shift_q,   shift_d;
   logic [BCD_W-1:0]        scratch_q, scratch_d;
   logic [COUNT_BITS-1:0]   cnt_q,     cnt_d;
   logic                    ready_q,   ready_d;
   logic                    valid_q,   valid_d;
   logic [BCD_W-1:0]        bcd_q,     bcd_d;
   logic [DIGITS-1:0]       blank_q,   blank_d;

   logic [BCD_W-1:0]        adj;
   logic                    higher_zero;

   // Next-state, datapath and output decode
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      valid_d     = 1'b0;
      bcd_d       = bcd_q;
      blank_d     = blank_q;
      adj         = scratch_q;
      higher_zero = 1'b1;

      // Add-3 correction: a nibble >= 5 would exceed 9 after doubling
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d   = bus.binary;
               scratch_d = '0;
               cnt_d     = '0;
               ready_d   = 1'b0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            // Shift the combined register; binary MSB enters scratch bit 0
            {scratch_d, shift_d} = {adj, shift_q} << 1;
            cnt_d = cnt_q + COUNT_BITS'(1);

            if (cnt_q == COUNT_BITS'(WIDTH - 1)) begin
               bcd_d = scratch_d;
               // Digit i blanks only when it and every digit above it are zero
               for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                  higher_zero = higher_zero & (scratch_d[4*i +: 4] == 4'd0);
                  blank_d[i]  = higher_zero;
               end
               blank_d[0] = 1'b0;
               valid_d    = 1'b1;
               ready_d    = 1'b1;
               state_d    = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         bcd_q     <= '0;
         blank_q   <= BLANK_RST;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.valid = valid_q;
   assign bus.bcd   = bcd_q;
   assign bus.blank = blank_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: table-driven vectors plus
// hand-written sequences, checked through a scoreboard and a cycle model of
// the ready/valid timing.
module tb_product_bcd_converter;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DIGITS = 3;

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] bcd;
      logic [2:0]  blank;
   } vec_t;

   logic clock;
   logic reset;

   product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .COUNT_BITS(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [14:0] sb_q[$];
   logic [14:0] cur_exp = '0;

   int          busy_left = 0;
   bit          armed     = 0;
   bit          exp_ready = 1'b1;
   bit          exp_valid = 1'b0;
   logic [11:0] exp_bcd   = 12'h000;
   logic [2:0]  exp_blank = 3'b110;
   int          valid_cnt = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s at %0t", nm, $time);
   endfunction

   // Decimal reference: {bcd[11:0], blank[2:0]}
   function automatic logic [14:0] ref_conv(input int v);
      int d2, d1, d0;
      logic [2:0] bl;
      d2 = v / 100;
      d1 = (v / 10) % 10;
      d0 = v % 10;
      bl[2] = (d2 == 0);
      bl[1] = (d2 == 0) && (d1 == 0);
      bl[0] = 1'b0;
      return {4'(d2), 4'(d1), 4'(d0), bl};
   endfunction

   // Monitor: compare against the model, then predict the next cycle
   always @(negedge clock) begin
      if (armed) begin
         if (exp_valid) begin
            if (sb_q.size() == 0) begin
               fail_now("scoreboard_empty");
            end else begin
               {exp_bcd, exp_blank} = sb_q.pop_front();
            end
         end
         chk("ready", 32'(bus.ready), 32'(exp_ready));
         chk("valid", 32'(bus.valid), 32'(exp_valid));
         chk("bcd",   32'(bus.bcd),   32'(exp_bcd));
         chk("blank", 32'(bus.blank), 32'(exp_blank));
      end
      if (bus.valid === 1'b1) valid_cnt++;

      if (reset) begin
         busy_left = 0;
         sb_q.delete();
         exp_ready = 1'b1;
         exp_valid = 1'b0;
         exp_bcd   = 12'h000;
         exp_blank = 3'b110;
         armed     = 1'b1;
      end else if (armed) begin
         exp_valid = 1'b0;
         if (busy_left == 0) begin
            if (bus.start === 1'b1) begin
               sb_q.push_back(cur_exp);
               busy_left = WIDTH;
               exp_ready = 1'b0;
            end
         end else begin
            busy_left--;
            if (busy_left == 0) begin
               exp_ready = 1'b1;
               exp_valid = 1'b1;
            end
         end
      end
   end

   // Present a value and wait (bounded) for its accept edge
   task automatic send(input logic [7:0] b, input logic [14:0] e, input bit keep);
      int n = 0;
      @(posedge clock); #1;
      bus.start  = 1'b1;
      bus.binary = b;
      cur_exp    = e;
      do begin
         @(negedge clock);
         n++;
      end while (bus.ready !== 1'b1 && n < 40);
      if (bus.ready !== 1'b1) fail_now("accept_timeout");
      @(posedge clock); #1;
      if (!keep) bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while ((sb_q.size() != 0 || busy_left != 0) && n < 40);
      if (sb_q.size() != 0 || busy_left != 0) fail_now("drain_timeout");
      @(posedge clock); #1;
   endtask

   initial begin
      vec_t vecs[8];
      int   vc0;

      vecs[0] = '{8'd0,   12'h000, 3'b110};
      vecs[1] = '{8'd9,   12'h009, 3'b110};
      vecs[2] = '{8'd99,  12'h099, 3'b100};
      vecs[3] = '{8'd100, 12'h100, 3'b000};
      vecs[4] = '{8'd255, 12'h255, 3'b000};
      vecs[5] = '{8'd225, 12'h225, 3'b000};
      vecs[6] = '{8'd42,  12'h042, 3'b100};
      vecs[7] = '{8'd200, 12'h200, 3'b000};

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.binary = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_bcd",   32'(bus.bcd),   32'h000);
      chk("rst_blank", 32'(bus.blank), 32'b110);

      // Single conversion of 15 x 15
      send(vecs[5].bin, {vecs[5].bcd, vecs[5].blank}, 1'b0);
      wait_idle();

      // Back-to-back with start held high, reissued on each valid cycle
      vc0 = valid_cnt;
      for (int i = 0; i < 5; i++) begin
         send(vecs[i].bin, {vecs[i].bcd, vecs[i].blank}, 1'b1);
      end
      bus.start = 1'b0;
      wait_idle();
      chk("b2b_valid_count", 32'(valid_cnt - vc0), 32'd5);

      // start pulses during a conversion are ignored
      vc0 = valid_cnt;
      send(vecs[6].bin, {vecs[6].bcd, vecs[6].blank}, 1'b0);
      @(posedge clock); #1;
      bus.start = 1'b1; bus.binary = 8'd99;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clock); #1;
      bus.start = 1'b1; bus.binary = 8'd77;
      @(posedge clock); #1;
      bus.start = 1'b0;
      wait_idle();
      repeat (10) @(posedge clock); #1;
      chk("ignored_start_valid_count", 32'(valid_cnt - vc0), 32'd1);
      chk("ignored_start_bcd", 32'(bus.bcd), 32'h042);

      // Reset in the middle of a conversion of 200
      vc0 = valid_cnt;
      send(vecs[7].bin, {vecs[7].bcd, vecs[7].blank}, 1'b0);
      repeat (3) @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("abort_ready", 32'(bus.ready), 32'd1);
      chk("abort_bcd",   32'(bus.bcd),   32'h000);
      repeat (12) @(posedge clock); #1;
      chk("abort_no_valid", 32'(valid_cnt - vc0), 32'd0);
      send(vecs[7].bin, {vecs[7].bcd, vecs[7].blank}, 1'b0);
      wait_idle();
      chk("after_abort_bcd", 32'(bus.bcd), 32'h200);

      // Every 4x4 product
      vc0 = valid_cnt;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(8'(a * b), ref_conv(a * b), 1'b1);
         end
      end
      bus.start = 1'b0;
      wait_idle();
      chk("sweep_valid_count", 32'(valid_cnt - vc0), 32'd256);
      chk("sweep_queue_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
